tcu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one ternary compute unit (TCU) among up to NUM_REQ requesters, such as the microcode sequencer, the integer pipeline and the debug port. Each grant runs one complete TCU transaction:
- captures the winner's opcode and operands;
- drives the TCU enable/valid/ready handshake;
- returns result and error to the winner;
- enforces a response timeout.

The block sits between the requesters and the single TCU instance.

---
 rtl/tcu_arbiter_pkg.sv | 22 ++
 rtl/tcu_arbiter_picker.sv | 38 +++
 rtl/tcu_arbiter.sv | 165 ++++++++++++++++
 tb/tb_tcu_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcu_arbiter_pkg.sv
// Shared constants for the TCU arbiter: opcode values and the FSM state
// encoding exposed on the debug `state` port.
package tcu_arbiter_pkg;

    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned OPERAND_W = 36;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_MUL = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_DIV = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_ABS = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_t;

endpackage

// File: rtl/tcu_arbiter_picker.sv
// Round-robin priority picker: first requester found searching upward from
// last_grant+1, wrapping modulo NUM_REQ.
import tcu_arbiter_pkg::*;

module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic [ID_W-1:0]    winner_idx,
    output logic               any_req
);

    logic [31:0] base;
    logic        found;

    assign base    = 32'(last_grant);
    assign any_req = |req;

    // Outer loop walks priority order; inner loop keeps every index constant.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == (base + off) % NUM_REQ) && req[i]) begin
                    found      = 1'b1;
                    winner[i]  = 1'b1;
                    winner_idx = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/tcu_arbiter.sv
// Shares one ternary compute unit among NUM_REQ requesters: round-robin grant,
// operand capture, TCU handshake, response return and response timeout.
import tcu_arbiter_pkg::*;

module tcu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*4-1:0]   req_operation,
    input  logic [NUM_REQ*36-1:0]  req_operand_a,
    input  logic [NUM_REQ*36-1:0]  req_operand_b,
    input  logic [NUM_REQ*36-1:0]  req_operand_c,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [35:0]            rsp_result,
    output logic                   rsp_error,
    output logic                   rsp_timeout,
    output logic                   tcu_enable,
    output logic [3:0]             tcu_operation,
    output logic [35:0]            tcu_operand_a,
    output logic [35:0]            tcu_operand_b,
    output logic [35:0]            tcu_operand_c,
    input  logic [35:0]            tcu_result,
    input  logic                   tcu_valid,
    input  logic                   tcu_ready,
    input  logic                   tcu_error,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic [2:0]             state,
    output logic [31:0]            grant_count,
    output logic [15:0]            timeout_count
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t          cur_state;
    logic [ID_W-1:0]     last_grant;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [CNT_W-1:0]    wait_cnt;

    logic [NUM_REQ-1:0]  win_onehot;
    logic [ID_W-1:0]     win_idx;
    logic                any_req;

    logic [3:0]          sel_op;
    logic [35:0]         sel_a;
    logic [35:0]         sel_b;
    logic [35:0]         sel_c;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any_req    (any_req)
    );

    // One-hot mux of the winner's payload; no variable part-selects needed.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_c  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                sel_op = sel_op | req_operation[i*4 +: 4];
                sel_a  = sel_a  | req_operand_a[i*36 +: 36];
                sel_b  = sel_b  | req_operand_b[i*36 +: 36];
                sel_c  = sel_c  | req_operand_c[i*36 +: 36];
            end
        end
    end

    assign state = cur_state;
    assign busy  = (cur_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state     <= ST_IDLE;
            last_grant    <= ID_W'(NUM_REQ - 1);
            grant_onehot  <= '0;
            wait_cnt      <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_result    <= '0;
            rsp_error     <= 1'b0;
            rsp_timeout   <= 1'b0;
            tcu_enable    <= 1'b0;
            tcu_operation <= '0;
            tcu_operand_a <= '0;
            tcu_operand_b <= '0;
            tcu_operand_c <= '0;
            grant_id      <= '0;
            grant_count   <= '0;
            timeout_count <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (cur_state)
                ST_IDLE: begin
                    if (any_req && tcu_ready) begin
                        tcu_operation <= sel_op;
                        tcu_operand_a <= sel_a;
                        tcu_operand_b <= sel_b;
                        tcu_operand_c <= sel_c;
                        req_ready     <= win_onehot;
                        grant_onehot  <= win_onehot;
                        grant_id      <= win_idx;
                        last_grant    <= win_idx;
                        grant_count   <= grant_count + 32'd1;
                        tcu_enable    <= 1'b1;
                        cur_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt  <= '0;
                    cur_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tcu_valid) begin
                        rsp_result  <= tcu_result;
                        rsp_error   <= tcu_error;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= grant_onehot;
                        tcu_enable  <= 1'b0;
                        cur_state   <= ST_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_result  <= '0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= grant_onehot;
                        tcu_enable  <= 1'b0;
                        if (timeout_count != '1) begin
                            timeout_count <= timeout_count + 16'd1;
                        end
                        cur_state   <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    cur_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!tcu_valid) begin
                        cur_state <= ST_IDLE;
                    end
                end
                default: begin
                    tcu_enable <= 1'b0;
                    cur_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcu_arbiter.sv
// Directed and randomized bench for tcu_arbiter with a behavioural TCU stub
// and a transaction-level round-robin reference model.
import tcu_arbiter_pkg::*;

module tb_tcu_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*4-1:0]    req_operation = '0;
    logic [N*36-1:0]   req_operand_a = '0;
    logic [N*36-1:0]   req_operand_b = '0;
    logic [N*36-1:0]   req_operand_c = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [35:0]       rsp_result;
    logic              rsp_error;
    logic              rsp_timeout;
    logic              tcu_enable;
    logic [3:0]        tcu_operation;
    logic [35:0]       tcu_operand_a;
    logic [35:0]       tcu_operand_b;
    logic [35:0]       tcu_operand_c;
    logic [35:0]       tcu_result;
    logic              tcu_valid;
    logic              tcu_ready = 1'b1;
    logic              tcu_error;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic [2:0]        state;
    logic [31:0]       grant_count;
    logic [15:0]       timeout_count;

    tcu_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_operation (req_operation),
        .req_operand_a (req_operand_a),
        .req_operand_b (req_operand_b),
        .req_operand_c (req_operand_c),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_result    (rsp_result),
        .rsp_error     (rsp_error),
        .rsp_timeout   (rsp_timeout),
        .tcu_enable    (tcu_enable),
        .tcu_operation (tcu_operation),
        .tcu_operand_a (tcu_operand_a),
        .tcu_operand_b (tcu_operand_b),
        .tcu_operand_c (tcu_operand_c),
        .tcu_result    (tcu_result),
        .tcu_valid     (tcu_valid),
        .tcu_ready     (tcu_ready),
        .tcu_error     (tcu_error),
        .busy          (busy),
        .grant_id      (grant_id),
        .state         (state),
        .grant_count   (grant_count),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // TCU behaviour shared by the stub and the expected-response calculation.
    function automatic void tcu_fn(input logic [3:0] op, input logic [35:0] a,
                                   input logic [35:0] b, output logic [35:0] r,
                                   output logic e);
        e = 1'b0;
        r = '0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_MUL: r = a * b;
            OP_DIV: if (b == '0) e = 1'b1; else r = a / b;
            OP_ABS: r = a[35] ? (~a + 36'd1) : a;
            default: e = 1'b1;
        endcase
    endfunction

    // Stub: operands latched on the first enable edge, valid `stub_delay`
    // edges later, valid dropped at the first edge that sees enable low.
    int stub_delay = 3;
    int stub_cnt;
    bit stub_started;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcu_valid    <= 1'b0;
            tcu_result   <= '0;
            tcu_error    <= 1'b0;
            stub_started <= 1'b0;
            stub_cnt     <= 0;
        end else if (!tcu_enable) begin
            tcu_valid    <= 1'b0;
            stub_started <= 1'b0;
            stub_cnt     <= 0;
        end else if (!stub_started) begin
            logic [35:0] r;
            logic        e;
            tcu_fn(tcu_operation, tcu_operand_a, tcu_operand_b, r, e);
            tcu_result   <= r;
            tcu_error    <= e;
            stub_started <= 1'b1;
            stub_cnt     <= 1;
            if (stub_delay == 1) tcu_valid <= 1'b1;
        end else if (!tcu_valid) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 == stub_delay) tcu_valid <= 1'b1;
        end
    end

    // Reference model state
    logic [N-1:0] mask;
    logic [3:0]   pay_op [N];
    logic [35:0]  pay_a  [N];
    logic [35:0]  pay_b  [N];
    logic [35:0]  pay_c  [N];
    int           m_last;
    int           m_grants;
    int           m_to;
    logic [35:0]  last_rsp;
    logic         last_err;

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int off = 1; off <= N; off++) begin
            if (m[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [35:0] a,
                           input logic [35:0] b, input logic [35:0] c);
        pay_op[i] = op; pay_a[i] = a; pay_b[i] = b; pay_c[i] = c;
        req_operation[i*4 +: 4]  = op;
        req_operand_a[i*36 +: 36] = a;
        req_operand_b[i*36 +: 36] = b;
        req_operand_c[i*36 +: 36] = c;
        req_valid[i] = 1'b1;
        mask[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        mask = '0;
        m_last = N - 1;
        m_grants = 0;
        m_to = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full transaction, checked against the model from grant to IDLE.
    task automatic run_txn(input string tag, input bit drop);
        int exp_id, cycles, waitc, exp_wait;
        logic [35:0] er;
        logic ee;
        bit eto;
        exp_id = rr_pick(mask, m_last);
        cycles = 0;
        while (req_ready == '0 && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_ready_seen"}, 64'(req_ready != '0), 64'd1);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1 << exp_id));
        chk({tag, "_grant_id"}, 64'(grant_id), 64'(exp_id));
        m_last = exp_id;
        m_grants++;
        chk({tag, "_grant_count"}, 64'(grant_count), 64'(m_grants));
        chk({tag, "_tcu_op"}, 64'(tcu_operation), 64'(pay_op[exp_id]));
        chk({tag, "_tcu_a"}, 64'(tcu_operand_a), 64'(pay_a[exp_id]));
        chk({tag, "_tcu_c"}, 64'(tcu_operand_c), 64'(pay_c[exp_id]));
        chk({tag, "_enable"}, 64'(tcu_enable), 64'd1);
        tcu_fn(pay_op[exp_id], pay_a[exp_id], pay_b[exp_id], er, ee);
        eto = (stub_delay > TO);
        if (eto) begin
            er = '0;
            ee = 1'b1;
            m_to++;
        end
        exp_wait = eto ? TO : stub_delay;
        if (drop) begin
            req_valid[exp_id] = 1'b0;
            mask[exp_id] = 1'b0;
        end
        waitc = 0;
        cycles = 0;
        while (state != 3'd3 && cycles < 200) begin
            @(negedge clk);
            if (state == 3'd2) waitc++;
            cycles++;
        end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1 << exp_id));
        chk({tag, "_rsp_result"}, 64'(rsp_result), 64'(er));
        chk({tag, "_rsp_error"}, 64'(rsp_error), 64'(ee));
        chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(eto));
        chk({tag, "_timeout_count"}, 64'(timeout_count), 64'(m_to));
        chk({tag, "_wait_cycles"}, 64'(waitc), 64'(exp_wait));
        last_rsp = rsp_result;
        last_err = rsp_error;
        @(negedge clk);
        chk({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
        cycles = 0;
        while (state != 3'd0 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        int order [5] = '{0, 1, 2, 3, 0};
        mask = '0;
        m_last = N - 1;
        m_grants = 0;
        m_to = 0;

        // Reset values
        #3;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_outputs", 64'({req_ready, rsp_valid, tcu_enable, busy, grant_id}), 64'd0);
        chk("rst_counts", 64'({grant_count, timeout_count}), 64'd0);
        do_reset();

        // 1: single request, held off while the TCU reports not ready
        tcu_ready = 1'b0;
        set_req(0, OP_ADD, 36'd5, 36'd3, 36'd0);
        repeat (4) @(negedge clk);
        chk("t1_hold_state", 64'(state), 64'd0);
        chk("t1_hold_ready", 64'(req_ready), 64'd0);
        tcu_ready = 1'b1;
        run_txn("t1", 1'b1);
        chk("t1_result", 64'(last_rsp), 64'd8);
        chk("t1_error", 64'(last_err), 64'd0);
        chk("t1_grants", 64'(grant_count), 64'd1);

        // 2: contention from reset
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, OP_ADD, 36'(i * 10), 36'(i + 1), 36'(i));
        for (int k = 0; k < 5; k++) begin
            run_txn("t2", 1'b0);
            chk("t2_order", 64'(grant_id), 64'(order[k]));
        end
        req_valid = '0;
        mask = '0;
        @(negedge clk);

        // 3: divide by zero then a normal request
        set_req(1, OP_DIV, 36'd100, 36'd0, 36'd0);
        run_txn("t3_div", 1'b1);
        chk("t3_div_result", 64'(last_rsp), 64'd0);
        chk("t3_div_error", 64'(last_err), 64'd1);
        set_req(1, OP_SUB, 36'd50, 36'd8, 36'd0);
        run_txn("t3_next", 1'b1);
        chk("t3_next_result", 64'(last_rsp), 64'd42);

        // 4: silent TCU
        stub_delay = 100000;
        set_req(2, OP_MUL, 36'd6, 36'd7, 36'd0);
        run_txn("t4", 1'b1);
        chk("t4_timeouts", 64'(timeout_count), 64'd1);

        // 5: valid arrives on the timeout edge
        stub_delay = TO;
        set_req(3, OP_MUL, 36'd6, 36'd7, 36'd1);
        run_txn("t5", 1'b1);
        chk("t5_result", 64'(last_rsp), 64'd42);
        stub_delay = 3;

        // 6: reset during WAIT
        stub_delay = 10;
        set_req(0, OP_ADD, 36'd1, 36'd1, 36'd0);
        seen = 0;
        while (state != 3'd2 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        chk("t6_in_wait", 64'(state), 64'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 64'(state), 64'd0);
        chk("t6_rst_enable", 64'(tcu_enable), 64'd0);
        chk("t6_rst_outs", 64'({busy, grant_id, rsp_valid, req_ready}), 64'd0);
        chk("t6_rst_regs", 64'({tcu_operation, tcu_operand_a}), 64'd0);
        chk("t6_rst_count", 64'(grant_count), 64'd0);
        req_valid = '0;
        mask = '0;
        m_last = N - 1;
        m_grants = 0;
        m_to = 0;
        stub_delay = 3;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid != '0 || req_ready != '0) seen++;
        end
        chk("t6_no_rsp", 64'(seen), 64'd0);
        set_req(2, OP_ABS, 36'hF_FFFF_FFFB, 36'd0, 36'd0);
        run_txn("t6_fresh", 1'b1);
        chk("t6_grant2", 64'(grant_id), 64'd2);
        chk("t6_abs", 64'(last_rsp), 64'd5);

        // Randomized traffic
        for (int it = 0; it < 25; it++) begin
            int dl [8] = '{1, 2, 3, 4, 5, TO, TO + 1, 3};
            for (int i = 0; i < N; i++) begin
                if (!mask[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 4'($urandom_range(0, 4)), {4'($urandom), $urandom},
                            {4'($urandom), $urandom}, {4'($urandom), $urandom});
            end
            if (mask == '0) set_req(int'($urandom_range(0, N - 1)), OP_ADD,
                                    36'($urandom), 36'($urandom), 36'd0);
            stub_delay = dl[$urandom_range(0, 7)];
            run_txn("rnd", 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
